// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: default decode address,
// FSM state encoding and FIFO pointer sizing.
package mmio_uart_tx_pkg;

    localparam logic [31:0] MMIO_UART_TX_ADDR = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // One extra pointer bit separates full from empty when the indices match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output and registered full/empty.
module sync_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_nxt  = wr_ptr + PW'(do_push);
    assign rd_nxt  = rd_ptr + PW'(do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Console UART transmitter: snoops CPU stores to TX_ADDR, queues the low byte,
// and sends each queued byte as an 8N1 frame, back to back when more are waiting.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = MMIO_UART_TX_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_data_write,
    input  logic [31:0] mem_data_addr_bus,
    input  logic [31:0] mem_data_write_bus,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [7:0]  drop_count
);
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg, fifo_dout;
    logic        push_req, pop, baud_end;
    logic        unused_hi;

    assign push_req  = mem_data_write && (mem_data_addr_bus == TX_ADDR);
    assign baud_end  = (baud_cnt == BAUD_MAX);
    assign pop       = !fifo_empty && (state == ST_IDLE || (state == ST_STOP && baud_end));
    assign unused_hi = ^mem_data_write_bus[31:8];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (mem_data_write_bus[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= 8'h00;
        end else if (push_req && fifo_full && !pop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'h01;
        end
    end

    // uart_tx follows the state one cycle later, so each symbol lasts exactly
    // CLKS_PER_BIT cycles on the line even across gapless STOP->START hand-offs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            uart_tx <= (state == ST_START) ? 1'b0 :
                       (state == ST_DATA)  ? shreg[0] : 1'b1;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shreg   <= fifo_dout;
                        state   <= ST_START;
                        tx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shreg <= fifo_dout;
                            state <= ST_START;
                        end else begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-position model compared every cycle, a line
// decoder, and directed literal checks.
module tb_mmio_uart_tx;
    localparam logic [31:0] TXA = 32'hFFFF_0000;
    localparam int CPB = 4;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0, wr6 = 1'b0;
    logic [31:0] addr = '0, data = '0, addr6 = '0, data6 = '0;
    logic        uart_tx, tx_busy, fifo_full, fifo_empty;
    logic [7:0]  drop_count;
    logic        uart6, busy6, full6, empty6;
    logic [7:0]  drop6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(.TX_ADDR(TXA), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .mem_data_write(wr), .mem_data_addr_bus(addr),
        .mem_data_write_bus(data), .uart_tx(uart_tx), .tx_busy(tx_busy),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_count(drop_count)
    );

    mmio_uart_tx #(.TX_ADDR(TXA), .CLKS_PER_BIT(65535), .FIFO_DEPTH(DEP)) dut6 (
        .clk(clk), .rst(rst), .mem_data_write(wr6), .mem_data_addr_bus(addr6),
        .mem_data_write_bus(data6), .uart_tx(uart6), .tx_busy(busy6),
        .fifo_full(full6), .fifo_empty(empty6), .drop_count(drop6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of bytes, frame position counter, line value from position.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_byte = '0;
    int         m_drop = 0;
    logic       m_line = 1'b1;
    logic       m_nline;
    bit         m_pop;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int s;
        s = pos / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_busy = 1'b0; m_pos = 0; m_byte = '0; m_drop = 0; m_line = 1'b1;
        end else begin
            m_nline = m_busy ? frame_bit(m_byte, m_pos) : 1'b1;
            m_pop = 1'b0;
            if (!m_busy) begin
                if (mq.size() > 0) m_pop = 1'b1;
            end else if (m_pos == 10*CPB-1) begin
                if (mq.size() > 0) m_pop = 1'b1;
                else m_busy = 1'b0;
            end else begin
                m_pos++;
            end
            if (m_pop) begin
                m_byte = mq.pop_front();
                m_pos  = 0;
                m_busy = 1'b1;
            end
            if (wr && addr == TXA) begin
                if (mq.size() < DEP) mq.push_back(data[7:0]);
                else if (m_drop != 255) m_drop++;
            end
            m_line = m_nline;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("uart_tx",    {31'b0, uart_tx},    {31'b0, m_line});
            chk("tx_busy",    {31'b0, tx_busy},    {31'b0, m_busy});
            chk("fifo_empty", {31'b0, fifo_empty}, (mq.size() == 0) ? 32'd1 : 32'd0);
            chk("fifo_full",  {31'b0, fifo_full},  (mq.size() == DEP) ? 32'd1 : 32'd0);
            chk("drop_count", {24'b0, drop_count}, m_drop);
        end
    end

    // Line decoder: samples mid-symbol after a falling start edge.
    logic [7:0] rx_q[$];
    logic [7:0] rx_b = '0;
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB/2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_b[rx_cnt/CPB - 1] = uart_tx;
            if (rx_cnt == 9*CPB + CPB/2) begin
                rx_q.push_back(rx_b);
                rx_act = 1'b0;
            end
        end
    end

    task automatic put(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = w; addr = a; data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr = 1'b0;
        end
    endtask

    logic [9:0] frame55;
    logic       exp_line;
    logic [7:0] exp3[6];

    initial begin
        frame55 = 10'b1_01010101_0;
        exp3 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h47};

        repeat (3) @(negedge clk);
        chk("rst_line",  {31'b0, uart_tx},    1);
        chk("rst_busy",  {31'b0, tx_busy},    0);
        chk("rst_empty", {31'b0, fifo_empty}, 1);
        chk("rst_full",  {31'b0, fifo_full},  0);
        chk("rst_drop",  {24'b0, drop_count}, 0);
        rst = 1'b1;
        idle(3);

        // single frame of 0x55
        put(1'b1, TXA, 32'h0000_0155);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            wr = 1'b0;
            exp_line = (k < 2 || k >= 42) ? 1'b1 : frame55[(k-2)/4];
            chk("t1_line", {31'b0, uart_tx}, {31'b0, exp_line});
            chk("t1_busy", {31'b0, tx_busy}, (k >= 1 && k <= 40) ? 32'd1 : 32'd0);
        end
        chk("t1_rx_n", rx_q.size(), 1);
        chk("t1_rx_byte", {24'b0, rx_q[0]}, 32'h55);

        // non-matching stores
        put(1'b1, TXA + 32'd4, 32'h11);
        put(1'b1, 32'h0, 32'h22);
        put(1'b0, TXA, 32'h33);
        idle(6);
        chk("t2_empty", {31'b0, fifo_empty}, 1);
        chk("t2_line",  {31'b0, uart_tx},    1);
        chk("t2_busy",  {31'b0, tx_busy},    0);

        // burst overflow, then a store on the STOP->START pop edge while full
        for (int i = 0; i < 6; i++) put(1'b1, TXA, 32'h41 + i);
        idle(35);
        put(1'b1, TXA, 32'h47);
        @(negedge clk);
        wr = 1'b0;
        chk("t4_drop", {24'b0, drop_count}, 1);
        chk("t4_full", {31'b0, fifo_full},  1);
        idle(250);
        chk("t3_rx_n", rx_q.size(), 7);
        for (int i = 0; i < 6; i++) chk("t3_rx_byte", {24'b0, rx_q[i+1]}, {24'b0, exp3[i]});

        // asynchronous reset mid-DATA
        put(1'b1, TXA, 32'h33);
        idle(15);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t5_line",  {31'b0, uart_tx},    1);
        chk("t5_busy",  {31'b0, tx_busy},    0);
        chk("t5_empty", {31'b0, fifo_empty}, 1);
        chk("t5_full",  {31'b0, fifo_full},  0);
        chk("t5_drop",  {24'b0, drop_count}, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        put(1'b1, TXA, 32'hA5);
        idle(50);
        chk("t5_rx_n", rx_q.size(), 8);
        chk("t5_rx_byte", {24'b0, rx_q[7]}, 32'hA5);

        // drop counter saturation on a stalled line
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 101) chk("t6_drop_100", {24'b0, drop6}, 95);
            if (i == 261) chk("t6_drop_260", {24'b0, drop6}, 255);
            wr6 = 1'b1; addr6 = TXA; data6 = i;
        end
        @(negedge clk);
        wr6 = 1'b0;
        chk("t6_drop_300", {24'b0, drop6}, 255);
        chk("t6_full",  {31'b0, full6},  1);
        chk("t6_empty", {31'b0, empty6}, 0);
        chk("t6_busy",  {31'b0, busy6},  1);
        chk("t6_line",  {31'b0, uart6},  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
